// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: FSM encoding, reset vector default and
// the decode constant that stops fetching.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [5:0]  FUNCT_HALT       = 6'h3F;
    localparam int          FETCH_ENTRY_W    = 64;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handshake.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_instr, if_pc, if_pc_plus4, opcode, funct,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_instr, if_pc, if_pc_plus4, opcode, funct,
        output if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} entries between fetch and decode.
// Flush wins over push and pop; storage is cleared by reset so the head reads 0.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && !flush && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && !flush && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding-request instruction fetcher feeding a small buffer toward
// decode; redirect flushes the buffer and may have to drop an in-flight response.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                halt,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    instr_fetch_unit_if.master  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic               req_q, req_d;

    logic               push, pop, flush, head_valid;
    logic [CNT_W-1:0]   count, post_count;
    logic [FETCH_ENTRY_W-1:0] head;
    logic [31:0]        redirect_tgt;
    logic [31:0]        head_pc;

    assign redirect_tgt = word_align(redirect_pc);
    assign head_valid   = (count != '0);
    assign pop          = head_valid && bus.if_ready;
    assign post_count   = count + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_d    = redirect_tgt;
                    state_d = REQ;
                end else if (state_q == IDLE) begin
                    if (halt)
                        state_d = HALTED;
                    else if (en && (count < CNT_W'(DEPTH)))
                        state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_d    = redirect_tgt;
                    state_d = bus.imem_ack ? REQ : DROP;
                end else if (bus.imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if (en && !halt && (post_count < CNT_W'(DEPTH)))
                        state_d = REQ;
                    else
                        state_d = halt ? HALTED : IDLE;
                end
            end
            DROP: begin
                // The stale response is swallowed; only the target moves.
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = redirect_tgt;
                end
                if (bus.imem_ack)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // DROP keeps presenting the abandoned address until its ack arrives.
    assign addr_d = (state_d == REQ) ? pc_d : addr_q;
    assign req_d  = (state_d == REQ) || (state_d == DROP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ({pc_q, bus.imem_rdata}),
        .head_data (head),
        .count     (count)
    );

    assign head_pc         = head[63:32];
    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.if_valid    = head_valid;
    assign bus.if_pc       = head_pc;
    assign bus.if_instr    = head[31:0];
    assign bus.if_pc_plus4 = head_pc + 32'd4;
    assign bus.opcode      = head[31:26];
    assign bus.funct       = head[5:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios plus a randomized run checked against an in-order
// expected-instruction queue for the fetch unit.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, halt, redirect;
    logic [31:0] redirect_pc;
    logic        rst2, en2, halt2, redir2;
    logic [31:0] redir_pc2;
    logic        auto_ack;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus2 ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .en(en), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .bus(bus)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .halt(halt2), .redirect(redir2),
        .redirect_pc(redir_pc2), .bus(bus2)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      q[$];
    logic [31:0] exp_fetch;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    int unsigned page;
    int          delivered;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {26'd0, FUNCT_HALT};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word(pc);
        chk1({tag, "_valid"}, bus.if_valid, 1'b1);
        chk({tag, "_pc"}, bus.if_pc, pc);
        chk({tag, "_instr"}, bus.if_instr, w);
        chk({tag, "_plus4"}, bus.if_pc_plus4, pc + 32'd4);
        chk({tag, "_opcode"}, {26'd0, bus.opcode}, {26'd0, w[31:26]});
        chk({tag, "_funct"}, {26'd0, bus.funct}, {26'd0, w[5:0]});
    endtask

    task automatic step();
        bus2.imem_ack   = bus2.imem_req;
        bus2.imem_rdata = mem_word(bus2.imem_addr);
        if (auto_ack) begin
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = mem_word(bus.imem_addr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_cycle(input bit drain);
        logic        r, rdy, ack, pop_m;
        logic [31:0] tgt;
        chk1("rnd_valid", bus.if_valid, q.size() != 0);
        chk1("rnd_depth", q.size() <= 2, 1'b1);
        if (q.size() != 0) begin
            chk("rnd_pc", bus.if_pc, q[0].pc);
            chk("rnd_instr", bus.if_instr, q[0].instr);
            chk("rnd_plus4", bus.if_pc_plus4, q[0].pc + 32'd4);
        end
        if (prev_req && !prev_ack) begin
            chk1("rnd_req_hold", bus.imem_req, 1'b1);
            chk("rnd_addr_hold", bus.imem_addr, prev_addr);
        end
        if (bus.imem_req)
            chk("rnd_addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);

        r   = !drain && ($urandom_range(0, 99) < 4);
        rdy = !r && (drain || ($urandom_range(0, 3) != 0));
        ack = bus.imem_req && ($urandom_range(0, 2) != 0);
        tgt = (page << 20) | 32'($urandom_range(0, 1023));
        if (r) page++;
        en             = drain ? 1'b0 : ($urandom_range(0, 7) != 0);
        redirect       = r;
        redirect_pc    = tgt;
        bus.if_ready   = rdy;
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_word(bus.imem_addr) : $urandom;

        // Expected stream: only a response to the next expected address is kept.
        pop_m = (q.size() != 0) && rdy;
        if (r) begin
            q.delete();
            exp_fetch = tgt & ~32'h3;
        end else begin
            if (pop_m) begin
                void'(q.pop_front());
                delivered++;
            end
            if (ack && (bus.imem_addr == exp_fetch)) begin
                q.push_back({exp_fetch, mem_word(exp_fetch)});
                exp_fetch += 32'd4;
            end
        end
        prev_req  = bus.imem_req;
        prev_ack  = ack;
        prev_addr = bus.imem_addr;
        step();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        bus.if_ready = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; auto_ack = 1'b0;
        rst2 = 1'b0; en2 = 1'b1; halt2 = 1'b0; redir2 = 1'b0; redir_pc2 = 32'd0;
        bus2.if_ready = 1'b1; bus2.imem_ack = 1'b0; bus2.imem_rdata = 32'd0;
        page = 1; delivered = 0;

        @(negedge clk);
        step();
        chk1("rst_req", bus.imem_req, 1'b0);
        chk1("rst_valid", bus.if_valid, 1'b0);
        chk("rst_instr", bus.if_instr, 32'd0);
        chk("rst_pc", bus.if_pc, 32'd0);
        chk("rst_opcode", {26'd0, bus.opcode}, 32'd0);
        chk("rst_funct", {26'd0, bus.funct}, 32'd0);

        // Back-to-back streaming from reset
        rst = 1'b1; en = 1'b1; bus.if_ready = 1'b1; auto_ack = 1'b1;
        step();
        chk1("a_req", bus.imem_req, 1'b1);
        chk("a_addr", bus.imem_addr, 32'd0);
        chk1("a_valid", bus.if_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_head($sformatf("a_seq%0d", k), 32'(4 * k));
        end

        // Decode stalled: buffer fills, fetch stops, then resumes at 8
        rst = 1'b0; step(); rst = 1'b1; bus.if_ready = 1'b0;
        step();
        chk1("b_req0", bus.imem_req, 1'b1);
        chk("b_addr0", bus.imem_addr, 32'd0);
        step();
        chk("b_addr1", bus.imem_addr, 32'd4);
        check_head("b_h0", 32'd0);
        step();
        chk1("b_full_req", bus.imem_req, 1'b0);
        step(); step();
        chk1("b_hold_req", bus.imem_req, 1'b0);
        check_head("b_hold", 32'd0);
        bus.if_ready = 1'b1;
        step();
        chk1("b_drain_req", bus.imem_req, 1'b0);
        check_head("b_h1", 32'd4);
        step();
        chk1("b_resume_req", bus.imem_req, 1'b1);
        chk("b_resume_addr", bus.imem_addr, 32'd8);
        chk1("b_resume_valid", bus.if_valid, 1'b0);
        step();
        check_head("b_h2", 32'd8);

        // Redirect with an ack pending: old address held, old data dropped
        auto_ack = 1'b0; bus.imem_ack = 1'b0; bus.if_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step(); redirect = 1'b0;
        chk1("c_req", bus.imem_req, 1'b1);
        chk("c_hold1", bus.imem_addr, 32'd12);
        chk1("c_flush", bus.if_valid, 1'b0);
        step();
        chk("c_hold2", bus.imem_addr, 32'd12);
        chk1("c_empty2", bus.if_valid, 1'b0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        step(); bus.imem_ack = 1'b0;
        chk("c_new_addr", bus.imem_addr, 32'h100);
        chk1("c_discard", bus.if_valid, 1'b0);
        auto_ack = 1'b1;
        step();
        check_head("c_h", 32'h100);

        // Halt with a request outstanding, then restart by redirect
        auto_ack = 1'b0; bus.imem_ack = 1'b0; halt = 1'b1; bus.if_ready = 1'b1;
        step();
        chk1("d_req", bus.imem_req, 1'b1);
        chk("d_addr", bus.imem_addr, 32'h104);
        bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h104);
        step(); bus.imem_ack = 1'b0;
        chk1("d_halt_req", bus.imem_req, 1'b0);
        check_head("d_last", 32'h104);
        step();
        chk1("d_drained", bus.if_valid, 1'b0);
        halt = 1'b0;
        step(); step();
        chk1("d_stay_halted", bus.imem_req, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); redirect = 1'b0;
        chk1("d_restart_req", bus.imem_req, 1'b1);
        chk("d_restart_addr", bus.imem_addr, 32'h40);
        auto_ack = 1'b1;
        step();
        check_head("d_h40", 32'h40);

        // Reset while dropping; a late ack must not push
        auto_ack = 1'b0; bus.imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        step(); redirect = 1'b0;
        chk("e_drop_addr", bus.imem_addr, 32'h44);
        rst = 1'b0; step(); rst = 1'b1; en = 1'b0;
        chk1("e_req", bus.imem_req, 1'b0);
        chk1("e_valid", bus.if_valid, 1'b0);
        chk("e_pc", bus.if_pc, 32'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_0BAD;
        step(); bus.imem_ack = 1'b0;
        chk1("e_late_valid", bus.if_valid, 1'b0);
        chk1("e_late_req", bus.imem_req, 1'b0);
        en = 1'b1;
        step();
        chk("e_restart_addr", bus.imem_addr, 32'd0);
        step();
        chk1("e_no_push", bus.if_valid, 1'b0);

        // Address wrap from the top of memory
        rst2 = 1'b1;
        step();
        chk("f_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("f_pc0", bus2.if_pc, 32'hFFFF_FFFC);
        chk("f_plus4_0", bus2.if_pc_plus4, 32'd0);
        chk("f_instr0", bus2.if_instr, mem_word(32'hFFFF_FFFC));
        step();
        chk("f_pc1", bus2.if_pc, 32'd0);
        chk("f_plus4_1", bus2.if_pc_plus4, 32'd4);

        // Randomized run against the expected-instruction queue
        rst = 1'b0; step(); rst = 1'b1;
        q.delete(); exp_fetch = 32'd0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
        for (int i = 0; i < 2500; i++) rand_cycle(1'b0);
        for (int i = 0; i < 40; i++) rand_cycle(1'b1);
        chk1("rnd_final_valid", bus.if_valid, 1'b0);
        chk1("rnd_final_req", bus.imem_req, 1'b0);
        chk1("rnd_progress", delivered >= 300, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries; only DEPTH=2 is required to work.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 en  in  1  fetch enable; 0 = issue no new requests.
REQ-006 halt  in  1  level from decode (HALT funct seen); stops fetching.
REQ-007 redirect  in  1  branch/jump taken; flushes the block and restarts at redirect_pc.
REQ-008 redirect_pc  in  32  target address; bits [1:0] are ignored and treated as 0.
REQ-009 imem_req  out  1  request valid to instruction memory.
REQ-010 imem_addr  out  32  word-aligned request address; held stable while imem_req=1 and imem_ack=0.
REQ-011 imem_ack  in  1  response valid; may assert in the same cycle as imem_req.
REQ-012 imem_rdata  in  32  instruction word; sampled when imem_ack=1.
REQ-013 if_valid  out  1  buffer head valid toward decode.
REQ-014 if_ready  in  1  decode accepts the head entry.
REQ-015 if_instr  out  32  head instruction word.
REQ-016 if_pc  out  32  head instruction address.
REQ-017 if_pc_plus4  out  32  if_pc+4, modulo 2^32.
REQ-018 opcode  out  6  if_instr[31:26], routed to the control unit IR input.
REQ-019 funct  out  6  if_instr[5:0], routed to the control unit Funct input.

Function
REQ-020 FSM states: IDLE, REQ, DROP, HALTED; REQ and DROP drive imem_req=1, IDLE and HALTED drive imem_req=0.
REQ-021 Outstanding requests: at most one.
REQ-022 IDLE->REQ: when en=1, halt=0 and buffer count<2; imem_addr=pc.
REQ-023 REQ with ack=1: push {pc,imem_rdata}, pc<=pc+4 (wrap to 0 after 32'hFFFF_FFFC).
  - Next state REQ if en=1, halt=0 and post-push count<2; otherwise IDLE.
REQ-024 Back-to-back: with ack every cycle and if_ready=1, one instruction is delivered per cycle.
REQ-025 Pop: when if_valid=1 and if_ready=1; simultaneous push and pop leaves count unchanged; a push never occurs with count=2.
REQ-026 Fetch latency: an instruction acked at cycle N appears on if_* at cycle N+1.
REQ-027 Redirect has the highest priority and acts in the same cycle:
  - buffer is flushed (if_valid=0 next cycle); pc<=redirect_pc&~3.
  - In REQ with ack=0: go to DROP.
  - In REQ with ack=1 or in DROP with ack=1: discard the data and go to REQ.
  - In IDLE or HALTED: go to REQ.
REQ-028 DROP: hold the old imem_addr until ack, discard that response, then go to REQ at the new pc.
  - A further redirect during DROP only updates pc.
REQ-029 halt=1 in REQ: the outstanding request completes and its data is pushed, then the FSM goes to HALTED.
REQ-030 halt=1 in IDLE: go to HALTED.
REQ-031 HALTED exits only via redirect or reset; the buffer keeps draining to decode while halted.
REQ-032 en=0: behaves like halt except the next state is IDLE instead of HALTED.

Reset
REQ-033 When rst=0 at a clock edge, next cycle:
  - pc=RESET_PC, state=IDLE, count=0.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0, opcode=0, funct=0.
REQ-034 Reset mid-request abandons the request; any later imem_ack is ignored until a new request is issued.

Structure
REQ-035 Shared package mips_pkg holds the fetch_state_t enum, the RESET_PC default and the HALT funct constant.
REQ-036 The buffer is sub-module fetch_fifo: 2-entry, 64-bit {pc,instr}, push/pop/flush/count, synchronous active-low rst.

Verification
REQ-037 Reset release, en=1, ack same cycle every cycle, if_ready=1 -> if_pc sequence 0,4,8,12 on consecutive cycles.
REQ-038 if_ready=0 with continuous ack -> exactly 2 entries buffered, imem_req=0; then if_ready=1 -> entries delivered in order, fetch resumes at pc=8.
REQ-039 Redirect to 32'h100 while an ack is pending 3 cycles -> old address held, old data discarded, next if_pc=32'h100, buffer empty in between.
REQ-040 halt=1 with a request outstanding -> the acked word is delivered, then HALTED with imem_req=0; redirect to 32'h40 -> fetch restarts at 32'h40.
REQ-041 RESET_PC=32'hFFFF_FFFC, fetch two instructions -> if_pc FFFF_FFFC then 0000_0000, if_pc_plus4=0 for the first.
REQ-042 rst=0 during DROP -> next cycle IDLE, if_valid=0, imem_req=0; a late ack produces no push.
